// File: rtl/spi_cnn_master_8_if.sv
// Host-side bus of the CNN SPI master: frame request, row data, status,
// received byte and the four SPI wires. The master modport is the view of
// the SPI master itself; the slave modport is the view of whoever drives it.
interface spi_cnn_master_8_if #(
  parameter int DATAWIDTH_BUS = 8
);
  logic                     i_start;
  logic                     i_start_cnn;
  logic [DATAWIDTH_BUS-1:0] i_row00;
  logic [DATAWIDTH_BUS-1:0] i_row01;
  logic [DATAWIDTH_BUS-1:0] i_row02;
  logic [DATAWIDTH_BUS-1:0] i_row03;
  logic [DATAWIDTH_BUS-1:0] i_row04;
  logic [DATAWIDTH_BUS-1:0] i_row05;
  logic [DATAWIDTH_BUS-1:0] i_row06;
  logic [DATAWIDTH_BUS-1:0] i_row07;
  logic                     o_busy;
  logic                     o_done;
  logic [DATAWIDTH_BUS-1:0] o_rx_data;
  logic                     o_SPI_Clk;
  logic                     o_SPI_CS_n;
  logic                     o_SPI_MOSI;
  logic                     i_SPI_MISO;

  modport master (
    input  i_start, i_start_cnn,
    input  i_row00, i_row01, i_row02, i_row03,
    input  i_row04, i_row05, i_row06, i_row07,
    input  i_SPI_MISO,
    output o_busy, o_done, o_rx_data,
    output o_SPI_Clk, o_SPI_CS_n, o_SPI_MOSI
  );

  modport slave (
    output i_start, i_start_cnn,
    output i_row00, i_row01, i_row02, i_row03,
    output i_row04, i_row05, i_row06, i_row07,
    output i_SPI_MISO,
    input  o_busy, o_done, o_rx_data,
    input  o_SPI_Clk, o_SPI_CS_n, o_SPI_MOSI
  );
endinterface

// File: rtl/spi_cnn_master_8.sv
// SPI mode-0 master that ships one CNN input frame ({cmd, row00..row07},
// MSB first) to the accelerator's SPI slave and returns the last byte seen
// on MISO. Chip select wraps the frame with CLKDIV-cycle setup and hold
// guards; a start seen in the done cycle chains frames with a single
// CS_n-high cycle between them.
module spi_cnn_master_8 #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int CLKDIV        = 4
) (
  input logic                 spi_cnn_master_8_CLOCK_50,
  input logic                 spi_cnn_master_8_Reset_InHigh,
  spi_cnn_master_8_if.master  bus
);

  localparam int FRAME_BITS = 8 + 8 * DATAWIDTH_BUS;
  localparam int HALF_W     = $clog2(CLKDIV) + 1;

  localparam logic [HALF_W-1:0] HALF_RELOAD = HALF_W'(CLKDIV - 1);
  localparam logic [HALF_W-1:0] HALF_ONE    = HALF_W'(1);
  localparam logic [6:0]        BIT_LAST    = 7'(FRAME_BITS - 1);
  localparam logic [6:0]        BIT_ONE     = 7'd1;
  localparam logic [7:0]        CMD_LOAD       = 8'h01;
  localparam logic [7:0]        CMD_LOAD_START = 8'h02;

  typedef enum logic [2:0] {
    stIdle,
    stCsSetup,
    stXfer,
    stCsHold,
    stDone
  } spiState_t;

  spiState_t                state;
  spiState_t                stateNext;
  logic [HALF_W-1:0]        halfCnt;
  logic [6:0]               bitCnt;
  logic [FRAME_BITS-1:0]    frameReg;
  logic [DATAWIDTH_BUS-1:0] rxShift;
  logic [DATAWIDTH_BUS-1:0] rxData;
  logic                     sclk;

  logic                     inFrame;
  logic                     phaseEnd;
  logic                     startAccept;
  logic                     sclkRise;
  logic                     sclkFall;
  logic                     lastBit;
  logic [7:0]               cmdByte;
  logic [FRAME_BITS-1:0]    frameLoad;

  // Chip select is asserted across setup, transfer and hold.
  assign inFrame     = (state == stCsSetup) || (state == stXfer) || (state == stCsHold);
  assign phaseEnd    = (halfCnt == '0);
  // The done cycle is not busy, so a start there is taken immediately.
  assign startAccept = ((state == stIdle) || (state == stDone)) && bus.i_start;
  assign sclkRise    = (state == stXfer) && phaseEnd && !sclk;
  assign sclkFall    = (state == stXfer) && phaseEnd && sclk;
  assign lastBit     = (bitCnt == BIT_LAST);

  assign cmdByte   = bus.i_start_cnn ? CMD_LOAD_START : CMD_LOAD;
  assign frameLoad = {cmdByte,
                      bus.i_row00, bus.i_row01, bus.i_row02, bus.i_row03,
                      bus.i_row04, bus.i_row05, bus.i_row06, bus.i_row07};

  // State register; reset always lands in IDLE, abandoning any frame.
  always_ff @(posedge spi_cnn_master_8_CLOCK_50) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (spi_cnn_master_8_Reset_InHigh) begin
      state <= stIdle;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: each guard phase ends when the half-period counter
  // expires; the transfer ends on the falling edge of the last bit.
  always_comb begin
    // NOTE: default first so no path through the case leaves stateNext
    // unassigned, which would infer a latch.
    stateNext = state;
    case (state)
      stIdle, stDone: begin
        stateNext = startAccept ? stCsSetup : stIdle;
      end
      stCsSetup: begin
        if (phaseEnd) stateNext = stXfer;
      end
      stXfer: begin
        if (sclkFall && lastBit) stateNext = stCsHold;
      end
      stCsHold: begin
        if (phaseEnd) stateNext = stDone;
      end
      default: stateNext = stIdle;
    endcase
  end

  // Half-period timer: reloads at every phase boundary inside the frame.
  always_ff @(posedge spi_cnn_master_8_CLOCK_50) begin
    if (spi_cnn_master_8_Reset_InHigh) begin
      halfCnt <= '0;
    end else if (startAccept || (inFrame && phaseEnd)) begin
      halfCnt <= HALF_RELOAD;
    end else if (inFrame) begin
      halfCnt <= halfCnt - HALF_ONE;
    end
  end

  // Serialiser: latch the frame on start, sample MISO as SCLK rises and
  // advance MOSI as SCLK falls; the last bit stays on MOSI through hold.
  always_ff @(posedge spi_cnn_master_8_CLOCK_50) begin
    if (spi_cnn_master_8_Reset_InHigh) begin
      frameReg <= '0;
      bitCnt   <= '0;
      rxShift  <= '0;
      sclk     <= 1'b0;
    end else if (startAccept) begin
      frameReg <= frameLoad;
      bitCnt   <= '0;
      rxShift  <= '0;
      sclk     <= 1'b0;
    end else if (sclkRise) begin
      sclk    <= 1'b1;
      rxShift <= {rxShift[DATAWIDTH_BUS-2:0], bus.i_SPI_MISO};
    end else if (sclkFall) begin
      sclk <= 1'b0;
      if (!lastBit) begin
        bitCnt   <= bitCnt + BIT_ONE;
        frameReg <= {frameReg[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  // Response byte: the last byte clocked in, published as DONE is entered.
  always_ff @(posedge spi_cnn_master_8_CLOCK_50) begin
    if (spi_cnn_master_8_Reset_InHigh) begin
      rxData <= '0;
    end else if ((state == stCsHold) && phaseEnd) begin
      rxData <= rxShift;
    end
  end

  assign bus.o_SPI_Clk  = sclk;
  assign bus.o_SPI_CS_n = !inFrame;
  assign bus.o_SPI_MOSI = inFrame ? frameReg[FRAME_BITS-1] : 1'b0;
  assign bus.o_busy     = inFrame;
  assign bus.o_done     = (state == stDone);
  assign bus.o_rx_data  = rxData;

endmodule

// File: doc/spi_cnn_master_8.md
# spi_cnn_master_8

SPI mode-0 master that serialises one CNN input frame toward `spi_cnn_slave_8`: a command byte followed by the eight 8-bit image rows, row00 first, MSB first. It is the host-side counterpart of the accelerator's SPI slave. It is used in the board-level bring-up top and as the stimulus driver in system benches. It captures MISO during the frame and returns the last received byte, which carries the slave's response.

## Interface
Parameters:
- `DATAWIDTH_BUS`, default 8, width of each row and of the rx byte. The frame-length arithmetic below assumes 8.
- `CLKDIV`, default 4, system clocks per SCLK half-period. Must be ≥ 1.

Ports:
- `spi_cnn_master_8_CLOCK_50`  in  1  single system clock; all logic on its rising edge.
- `spi_cnn_master_8_Reset_InHigh`  in  1  synchronous, active-high reset.
- `i_start`  in  1  frame request; sampled only while `o_busy`=0.
- `i_start_cnn`  in  1  sampled with `i_start`; 1 → command 0x02 (load + start CNN), 0 → command 0x01 (load only).
- `i_row00` … `i_row07`  in  8 each  row data, latched at the accepted start.
- `o_busy`  out  1  high from the cycle after start acceptance until the done cycle, exclusive.
- `o_done`  out  1  one-cycle pulse at frame end.
- `o_rx_data`  out  8  MISO byte sampled during the final frame byte; updated in the done cycle.
- `o_SPI_Clk`  out  1  SCLK, idle low.
- `o_SPI_CS_n`  out  1  chip select, active low.
- `o_SPI_MOSI`  out  1  serial data out.
- `i_SPI_MISO`  in  1  serial data in.

## Operation
- Frame: 72-bit shift register = {cmd, row00, …, row07}, sent MSB first. Exactly 72 SCLK pulses per frame.
- FSM states:
  - IDLE: accept start when `i_start`=1; latch the frame; → CS_SETUP.
  - CS_SETUP: lasts CLKDIV cycles; → XFER.
  - XFER: lasts 72 bits × 2·CLKDIV cycles; → CS_HOLD.
  - CS_HOLD: lasts CLKDIV cycles; → DONE.
  - DONE: lasts 1 cycle; → IDLE.
- Per bit in XFER:
  - SCLK is low for CLKDIV cycles, then high for CLKDIV cycles.
  - MISO is sampled into the rx shift register on the cycle SCLK goes high.
  - MOSI advances to the next bit on the cycle SCLK goes low, except after bit 72.
- Bit counter: 7 bits, 0..71; no wrap.
- Half-period counter: width $clog2(CLKDIV)+1; reloads at every phase change.
- `o_rx_data` is loaded from the rx shift register's low 8 bits when entering DONE.
- CS_n is low in CS_SETUP, XFER and CS_HOLD; high in IDLE and DONE.
- MOSI:
  - IDLE and DONE: 0.
  - CS_SETUP through CS_HOLD: the current frame bit. During CS_HOLD it holds the LSB of row07.
- Boundary rules:
  - `i_start` while `o_busy`=1 is ignored; nothing is queued.
  - Row and command inputs changing mid-frame have no effect.
  - `i_start` in the DONE cycle is accepted (`o_busy`=0 there), giving back-to-back frames with CS_n high for exactly 1 cycle.
  - Reset in any state: next cycle is IDLE with all outputs at reset values. No `o_done` pulse is issued for the aborted frame.

## Timing
- Reset values:
  - `o_SPI_CS_n`=1.
  - `o_SPI_Clk`=0, `o_SPI_MOSI`=0.
  - `o_busy`=0, `o_done`=0.
  - `o_rx_data`=0.
  - FSM in IDLE.
- Start accepted at cycle 0. At cycle 1:
  - CS_n=0.
  - MOSI = cmd[7].
  - `o_busy`=1.
- First SCLK rise: cycle 1+2·CLKDIV.
- Bit k (0-based) rises at cycle 1+2·CLKDIV+2k·CLKDIV.
- Last SCLK fall: cycle 1+145·CLKDIV.
- In the done cycle at 1+146·CLKDIV:
  - `o_done`=1.
  - CS_n=1.
  - `o_busy`=0.
  - `o_rx_data` is valid.
- With CLKDIV=4: first rise at cycle 9, done at cycle 585.
- MOSI is stable for CLKDIV cycles before and after every SCLK rise.

## Test plan
- **Basic frame.** CLKDIV=4, rows 0x01,0x02,0x04,…,0x80, `i_start_cnn`=0, single start → MOSI bits sampled at SCLK rises equal 0x01 followed by the rows in order. Exactly 72 rises, done at cycle 585, CS_n low for cycles 1–584.
- **Command select.** `i_start_cnn`=1, rows all 0xFF → first byte on MOSI is 0x02 and the remaining 64 bits are 1.
- **MISO loopback.** `i_SPI_MISO` tied to `o_SPI_MOSI`, row07=0xA5 → `o_rx_data`=0xA5 in the done cycle and held afterwards.
- **Start while busy.** Pulse `i_start` at cycle 100 with different rows → ignored; frame unchanged; single done pulse.
- **Reset mid-frame.** Assert reset at cycle 300 for 1 cycle → at cycle 301 CS_n=1, SCLK=0, MOSI=0, busy=0. No done pulse. A new start then produces a full, correct 585-cycle frame.
- **Back-to-back frames.** `i_start` held high across two frames, CLKDIV=1 → CS_n high for exactly 1 cycle between the frames. Both frames are bit-correct; the second done occurs 147 cycles after the first.
